iob_cache_write_buffer: RTL
===========================

Name: iob_cache_write_buffer

Overview:
Write-through buffer between the cache front-end and the back-end memory port. It queues {address, write data, byte strobe} entries in a register-file-style storage of 2**DEPTH_W entries and drains them in order over a valid/ready handshake. The controller uses empty_o to stall read misses until all pending writes have retired.

Parameters:
DEPTH_W, 2, log2 of entry count (depth = 2**DEPTH_W, min 1)
ADDR_W, 24, write address width
DATA_W, 32, write data width; strobe width = DATA_W/8

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  synchronous active-low reset
cke_i  input  1  clock enable; low freezes all state
push_valid_i  input  1  front-end write request
push_ready_o  output  1  buffer can accept (not full)
push_addr_i  input  ADDR_W  write address
push_data_i  input  DATA_W  write data
push_strb_i  input  DATA_W/8  byte strobes
mem_valid_o  output  1  head entry valid toward memory
mem_ready_i  input  1  memory accepts head entry
mem_addr_o  output  ADDR_W  head address
mem_data_o  output  DATA_W  head data
mem_strb_o  output  DATA_W/8  head strobes
level_o  output  DEPTH_W+1  occupied entries, 0..2**DEPTH_W
empty_o  output  1  level_o == 0
full_o  output  1  level_o == 2**DEPTH_W

Behaviour:
- Reset (rstn_i low at rising edge, regardless of cke_i): write pointer, read pointer and level cleared. After the edge: level_o=0, empty_o=1, full_o=0, push_ready_o=1, mem_valid_o=0. Storage is not reset. mem_addr_o, mem_data_o and mem_strb_o are undefined while mem_valid_o=0, and the bench must not check them then.
- Reset mid-operation discards all queued entries. Any handshake in the reset cycle is ignored.
- Storage: 2**DEPTH_W entries of ADDR_W+DATA_W+DATA_W/8 bits. Written at the write pointer on push; read combinationally at the read pointer.
- Pointers are DEPTH_W bits and wrap modulo 2**DEPTH_W. Full and empty are distinguished by level, not by pointer compare.
- push_ready_o = !full_o, combinational from level only. It never depends on mem_ready_i: no same-cycle push when full, even if a pop happens that cycle.
- Push fires when cke_i & push_valid_i & push_ready_o. The entry is written and the write pointer incremented at the edge.
- mem_valid_o = !empty_o. mem_addr_o, mem_data_o and mem_strb_o show the head entry.
- Pop fires when cke_i & mem_valid_o & mem_ready_i. The read pointer is incremented at the edge.
- Latency: an entry pushed at edge N appears at the head (if the buffer was empty) with mem_valid_o=1 in the cycle after edge N. There is no combinational bypass from push inputs to mem outputs.
- Head stability: while mem_valid_o=1 and mem_ready_i=0, mem_addr_o, mem_data_o and mem_strb_o hold constant. Pushes never alter the head entry.
- Level update per edge:
  - push only: level+1
  - pop only: level-1
  - push and pop: unchanged, both pointers advance
  - neither: unchanged
- Push and pop are simultaneous when the buffer is non-empty and non-full. The head is read before the same-edge write; entries are distinct unless depth is 1, in which case full blocks the push.
- Order: strict FIFO. Entries drain in push order, unmodified. Strobe value 0 is stored and forwarded as-is, not filtered.
- cke_i low: no push, no pop, pointers and level held. Outputs stay a function of the held state, so mem_valid_o may remain 1. Handshakes during cke_i=0 do not complete, and the upstream and downstream sides must hold their requests.
- push_valid_i while full: stalled (not dropped). Data must be held by the source until accepted.
- level_o, empty_o, full_o and push_ready_o are derived from registered state and are glitch-free at the cycle boundary.

Test Plan:
- Reset/idle: hold rstn_i=0 two cycles then release -> level_o=0, empty_o=1, full_o=0, push_ready_o=1, mem_valid_o=0.
- Single write latency: push addr=0x000100, data=0xDEADBEEF, strb=0xF at edge N, mem_ready_i=0 -> from edge N+1 mem_valid_o=1 with that entry stable, level_o=1. Raise mem_ready_i one cycle -> empty_o=1 after that edge.
- Fill and backpressure (DEPTH_W=2): push 4 entries with data=1..4, mem_ready_i=0 -> full_o=1, push_ready_o=0. A 5th push (data=5) is held. Drain one -> push_ready_o=1 the next cycle, data=5 accepted. Drain order is 1,2,3,4,5.
- Simultaneous push/pop at level 2 for 10 cycles with data 0x10..0x19 -> level_o stays 2. The output sequence equals the input order, and pointers wrap twice.
- Clock enable: level 3, toggle cke_i=0 for 5 cycles with push_valid_i=1 and mem_ready_i=1 -> level_o=3 and head unchanged throughout. Resume with cke_i=1 -> normal operation.
- Reset mid-drain: level 3, mem_ready_i=1, assert rstn_i=0 one cycle -> after the edge level_o=0 and mem_valid_o=0. The next pushed entry (data=0xA5A5A5A5) is the first drained.

Source files
------------

// File: rtl/iob_cache_write_buffer.sv
// Write-through buffer: in-order FIFO of {addr, data, strb} entries between the
// cache front-end and the memory port; level-based full/empty.
module iob_cache_write_buffer #(
    parameter int unsigned DEPTH_W = 2,
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cke_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [ADDR_W-1:0]     push_addr_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic [DATA_W/8-1:0]   push_strb_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [DATA_W/8-1:0]   mem_strb_o,
    output logic [DEPTH_W:0]      level_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W + STRB_W;
    localparam int unsigned DEPTH   = 2 ** DEPTH_W;

    localparam logic [DEPTH_W:0]   LEVEL_MAX = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0]   LEVEL_ONE = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE   = DEPTH_W'(1);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W:0]   level;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign empty_o      = (level == '0);
    assign full_o       = (level == LEVEL_MAX);
    assign level_o      = level;
    assign push_ready_o = !full_o;
    assign mem_valid_o  = !empty_o;

    assign push = cke_i & push_valid_i & push_ready_o;
    assign pop  = cke_i & mem_valid_o & mem_ready_i;

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            storage[wr_ptr] <= {push_addr_i, push_data_i, push_strb_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LEVEL_ONE;
            end else if (pop && !push) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

    assign head       = storage[rd_ptr];
    assign mem_addr_o = head[ENTRY_W-1 -: ADDR_W];
    assign mem_data_o = head[DATA_W+STRB_W-1 -: DATA_W];
    assign mem_strb_o = head[STRB_W-1:0];

endmodule
